// File: rtl/stream_argmax.sv
// Sequential argmax over a valid/ready stream of signed scores: one comparator,
// three-state controller, registered result with a frame-length error flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for beat 0; it seeds the running max unconditionally
// S_ACCUM | folding beats 1..N-1 into the running max / best index
// S_DONE  | result presented on m_*, input stalled until m_ready
module stream_argmax #(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 64,
   parameter int IDX_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [SCORE_W-1:0] s_score,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [IDX_W-1:0]   m_class,
   output logic [SCORE_W-1:0] m_max,
   output logic               m_err
);

   // One spare bit so count can reach N_CLASSES without wrapping.
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CLASSES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   count, count_nx;
   logic [IDX_W-1:0]   best_nx;
   logic [SCORE_W-1:0] max_nx;
   logic               err_nx;
   logic               accept;
   logic               at_final;
   logic               frame_end;
   logic               greater;

   assign accept    = s_valid && s_ready;
   assign at_final  = (count == LAST_IDX);
   assign frame_end = s_last || at_final;
   assign greater   = $signed(s_score) > $signed(m_max);

   always_comb begin
      state_nx = state;
      count_nx = count;
      best_nx  = m_class;
      max_nx   = m_max;
      err_nx   = m_err;
      case (state)
         S_IDLE: begin
            if (accept) begin
               max_nx   = s_score;
               best_nx  = '0;
               count_nx = CNT_W'(1);
               if (frame_end) begin
                  state_nx = S_DONE;
                  err_nx   = s_last ^ at_final;
               end else begin
                  state_nx = S_ACCUM;
               end
            end
         end
         S_ACCUM: begin
            if (accept) begin
               // Strict compare keeps the first of equal maxima.
               if (greater) begin
                  max_nx  = s_score;
                  best_nx = count[IDX_W-1:0];
               end
               count_nx = count + CNT_W'(1);
               if (frame_end) begin
                  state_nx = S_DONE;
                  err_nx   = s_last ^ at_final;
               end
            end
         end
         S_DONE: begin
            if (m_ready) begin
               state_nx = S_IDLE;
               count_nx = '0;
               err_nx   = 1'b0;
            end
         end
         default: begin
            state_nx = S_IDLE;
            count_nx = '0;
         end
      endcase
   end

   // Handshake flags are registered from the next state so s_ready never
   // depends combinationally on m_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         count   <= '0;
         m_class <= '0;
         m_max   <= '0;
         m_err   <= 1'b0;
         s_ready <= 1'b1;
         m_valid <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         m_class <= best_nx;
         m_max   <= max_nx;
         m_err   <= err_nx;
         s_ready <= (state_nx != S_DONE);
         m_valid <= (state_nx == S_DONE);
      end
   end

endmodule

// File: tb/tb_stream_argmax.sv
// Directed bench for stream_argmax: argmax, ties, signed extremes, malformed
// frames, input gaps, output back-pressure and mid-frame reset.
module tb_stream_argmax;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] s_score;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_class;
   logic [63:0] m_max;
   logic        m_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int first_acc;
   int prev_first;
   logic [63:0] sc [10];

   localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAX_S = 64'h7FFF_FFFF_FFFF_FFFF;

   stream_argmax #(.N_CLASSES(10), .SCORE_W(64), .IDX_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_score (s_score),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_class (m_class),
      .m_max   (m_max),
      .m_err   (m_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one beat and hold it until the DUT takes it; returns just after the accepting edge.
   task automatic send_beat(input logic [63:0] score, input logic last);
      bit taken;
      taken   = 1'b0;
      s_valid = 1'b1;
      s_score = score;
      s_last  = last;
      for (int t = 0; t < 100 && !taken; t++) begin
         taken = s_ready;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!taken) begin
         total++;
         bad++;
         $error("FAIL beat_accept_timeout observed=%0d expected=%0d", 0, 1);
      end
   endtask

   task automatic send_frame(input int n, input bit last_at_end, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         send_beat(sc[i], last_at_end && (i == n - 1));
         if (i == 0) first_acc = cyc;
      end
   endtask

   task automatic load_basic();
      sc[0] = 64'd5;  sc[1] = -64'sd3; sc[2] = 64'd12; sc[3] = 64'd7; sc[4] = 64'd0;
      sc[5] = 64'd11; sc[6] = 64'd2;   sc[7] = 64'd9;  sc[8] = 64'd1; sc[9] = 64'd4;
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_score = '0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
      chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_m_class", {60'd0, m_class}, 64'd0);
      chk("rst_m_max", m_max, 64'd0);
      chk("rst_m_err", {63'd0, m_err}, 64'd0);

      // Basic frame
      load_basic();
      send_frame(10, 1'b1, 1'b0);
      prev_first = first_acc;
      chk("basic_latency", {63'd0, m_valid}, 64'd1);
      chk("basic_class", {60'd0, m_class}, 64'd2);
      chk("basic_max", m_max, 64'd12);
      chk("basic_err", {63'd0, m_err}, 64'd0);

      // Ties and negatives, started right behind the basic frame
      for (int i = 0; i < 10; i++) sc[i] = -64'sd8;
      sc[4] = -64'sd1;
      sc[7] = -64'sd1;
      send_frame(10, 1'b1, 1'b0);
      chk("throughput", 64'(first_acc - prev_first), 64'd11);
      chk("ties_class", {60'd0, m_class}, 64'd4);
      chk("ties_max", m_max, 64'hFFFF_FFFF_FFFF_FFFF);

      // Signed extremes
      sc[0] = MIN_S;
      for (int i = 1; i < 10; i++) sc[i] = MAX_S;
      send_frame(10, 1'b1, 1'b0);
      chk("ext_class", {60'd0, m_class}, 64'd1);
      chk("ext_max", m_max, MAX_S);

      for (int i = 0; i < 9; i++) sc[i] = MIN_S;
      sc[9] = 64'd0;
      send_frame(10, 1'b1, 1'b0);
      chk("ext9_class", {60'd0, m_class}, 64'd9);
      chk("ext9_max", m_max, 64'd0);

      // Short frame: s_last on beat 5, maximum at beat 3
      sc[0] = 64'd1; sc[1] = 64'd2; sc[2] = 64'd3; sc[3] = 64'd50; sc[4] = 64'd4; sc[5] = 64'd5;
      send_frame(6, 1'b1, 1'b0);
      chk("short_valid", {63'd0, m_valid}, 64'd1);
      chk("short_err", {63'd0, m_err}, 64'd1);
      chk("short_class", {60'd0, m_class}, 64'd3);
      chk("short_max", m_max, 64'd50);

      // Ten beats with no s_last; beat 10 must wait for the handshake
      sc[0] = 64'd3; sc[1] = 64'd1; sc[2] = 64'd4; sc[3] = 64'd1; sc[4] = 64'd5;
      sc[5] = 64'd9; sc[6] = 64'd2; sc[7] = 64'd6; sc[8] = 64'd5; sc[9] = 64'd3;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      send_frame(10, 1'b0, 1'b0);
      chk("nolast_valid", {63'd0, m_valid}, 64'd1);
      chk("nolast_err", {63'd0, m_err}, 64'd1);
      chk("nolast_class", {60'd0, m_class}, 64'd5);
      s_valid = 1'b1;
      s_score = 64'd99;
      s_last  = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("beat10_blocked", {63'd0, s_ready}, 64'd0);
      chk("beat10_max_kept", m_max, 64'd9);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("nolast_handshake", {63'd0, m_valid}, 64'd0);

      // Well-formed frame after the errored one
      load_basic();
      send_frame(10, 1'b1, 1'b0);
      chk("good_err", {63'd0, m_err}, 64'd0);
      chk("good_class", {60'd0, m_class}, 64'd2);

      // Same frame with input gaps, then 20 cycles of back-pressure
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      send_frame(10, 1'b1, 1'b1);
      chk("gap_class", {60'd0, m_class}, 64'd2);
      chk("gap_max", m_max, 64'd12);
      chk("gap_err", {63'd0, m_err}, 64'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("hold_flags", {61'd0, m_valid, s_ready, m_err}, 64'b100);
         chk("hold_result", {m_max[59:0], m_class}, {60'd12, 4'd2});
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_release", {63'd0, m_valid}, 64'd0);

      // Reset after beat 6 of a frame whose partial max would dominate
      for (int i = 0; i < 10; i++) sc[i] = 64'd1000 + 64'(i);
      send_frame(7, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_valid", {63'd0, m_valid}, 64'd0);
      chk("midrst_ready", {63'd0, s_ready}, 64'd1);
      sc[0] = -64'sd5; sc[1] = -64'sd4; sc[2] = -64'sd3; sc[3] = -64'sd2; sc[4] = -64'sd1;
      sc[5] = -64'sd6; sc[6] = -64'sd7; sc[7] = -64'sd8; sc[8] = -64'sd9; sc[9] = -64'sd10;
      send_frame(10, 1'b1, 1'b0);
      chk("midrst_class", {60'd0, m_class}, 64'd4);
      chk("midrst_max", m_max, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("midrst_err", {63'd0, m_err}, 64'd0);

      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_argmax.md
# stream_argmax

Sequential classifier stage that sits directly downstream of `neural_net`. It consumes the network's output scores one per cycle over a valid/ready stream and reports the index of the largest score as the classified digit. It replaces the combinational 10-way compare tree with a single comparator and a small state machine. It also flags malformed frames.

## Interface

Parameters:
- `N_CLASSES`, default 10: scores per frame; must be ≥ 2.
- `SCORE_W`, default 64: score width; scores are signed two's complement.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W ≥ N_CLASSES.

Ports:
- `clk` — input, 1: the single clock; all logic is rising-edge.
- `rst_n` — input, 1: synchronous, active-low reset.
- `s_valid` — input, 1: input score valid.
- `s_ready` — output, 1: block can accept a score.
- `s_score` — input, `SCORE_W`: score for the current class index.
- `s_last` — input, 1: marks the final score of a frame.
- `m_valid` — output, 1: result valid.
- `m_ready` — input, 1: downstream accepts the result.
- `m_class` — output, `IDX_W`: index of the maximum score.
- `m_max` — output, `SCORE_W`: the maximum score value.
- `m_err` — output, 1: the frame length did not equal `N_CLASSES`.

## Operation

- **Beats.** An input beat is accepted on any cycle with `s_valid && s_ready`. Beat k of a frame (k = 0…N_CLASSES-1) is the score for class k.
- **States:**
  - **IDLE:** `s_ready`=1, `m_valid`=0. An accepted beat loads the running max with `s_score`, loads the best index with 0, and sets count=1. If that beat ends the frame, go to DONE; otherwise go to ACCUM.
  - **ACCUM:** `s_ready`=1. On each accepted beat:
    - If signed `s_score` > running max (strict), load running max with `s_score` and best index with count.
    - Increment count.
    - If the beat ends the frame, go to DONE.
  - **DONE:** `s_ready`=0, `m_valid`=1. Outputs are stable until `m_valid && m_ready`. On that cycle, clear `m_err` and count, then go to IDLE.
- **Frame end.** A beat ends the frame when `s_last`=1 or when it is beat N_CLASSES-1, whichever comes first.
- **Error flag.** `m_err`=1 if the frame ends with `s_last`=1 before beat N_CLASSES-1, or at beat N_CLASSES-1 without `s_last`. The result still reports the argmax over the beats actually received.
- **Ties.** Ties resolve to the lowest index; the first maximum is kept.
- **Signed compare.** The comparison is a full `SCORE_W`-bit signed compare with no truncation. The most negative value is a legal score.
- **Idle inputs.** `s_score` and `s_last` are ignored when `s_valid`=0.

## Timing

- **Reset values** (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `s_ready`=1 from the first cycle after reset.
  - `m_valid`=0, `m_class`=0, `m_max`=0, `m_err`=0.
  - count=0.
- **Reset mid-frame or in DONE:** any partial frame or pending result is discarded with no output.
- **Latency:** `m_valid` rises on the cycle after the frame-ending beat is accepted.
- **Throughput:** a back-to-back frame of N beats with `m_ready` held high takes N+1 cycles. The first beat of the next frame can be accepted the cycle after the result handshake.
- **Registered outputs:** all outputs are registered. `s_ready` is a function of state only, with no combinational path from `m_ready`.
- **Gaps:** `s_valid` gaps inside a frame are allowed. State and count hold during the gaps.
- **Back-pressure:** `m_ready`=0 in DONE holds the result indefinitely while `s_ready` stays 0.

## Test plan

- **Reset check.** Hold `rst_n`=0 for 3 cycles, then release. Require `s_ready`=1, `m_valid`=0, `m_class`=0, `m_max`=0, `m_err`=0.
- **Basic frame.** Send scores {5, -3, 12, 7, 0, 11, 2, 9, 1, 4}, `s_last` on beat 9, `m_ready`=1. Require `m_valid` exactly 1 cycle after beat 9, `m_class`=2, `m_max`=12, `m_err`=0, and the next frame accepted 11 cycles after the first beat.
- **Ties and negatives.** Send all scores equal to -8, except beat 4 = -1 and beat 7 = -1. Require `m_class`=4, `m_max`=-1.
- **Signed extremes.** Send beat 0 = 0x8000…0000 (most negative) and beats 1–9 = 0x7FFF…FFFF. Require `m_class`=1. Separately, send beat 9 as the only non-minimum score; require `m_class`=9.
- **Malformed frames:**
  - `s_last` on beat 5 with max at beat 3: require `m_err`=1, `m_class`=3.
  - 10 beats without `s_last`: require `m_err`=1 after beat 9, and beat 10 is not accepted before the handshake.
  - The following correct frame reports `m_err`=0.
- **Stalls and reset.**
  - Insert random `s_valid` gaps in a frame; the result must be identical to the gap-free result.
  - Hold `m_ready`=0 for 20 cycles in DONE; outputs must stay constant and `s_ready`=0.
  - Assert `rst_n`=0 after beat 6, then send a full frame; require the result to reflect only the new frame.
